// File: rtl/doodle_pkg.sv
// Shared definitions for the score path: screen codes, mode states, score width.
package doodle_pkg;

  localparam int SCORE_W = 11;

  localparam logic [2:0] SHOW_START = 3'd0;
  localparam logic [2:0] SHOW_OVER  = 3'd3;

  typedef enum logic [1:0] {
    START = 2'd0,
    PLAY  = 2'd1,
    OVER  = 2'd2
  } score_state_t;

  // Map the game screen code onto the score mode; every code that is neither
  // the start screen nor the drop screen counts as active play.
  function automatic score_state_t decode_show(input logic [2:0] show_code);
    if (show_code == SHOW_START) begin
      return START;
    end else if (show_code == SHOW_OVER) begin
      return OVER;
    end else begin
      return PLAY;
    end
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the VGA vsync into the system clock domain and turns each rising
// edge into a single-cycle registered pulse, three clocks after the edge.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset_n,
  input  logic async_in,
  output logic tick
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_tick;

  // Two-flop synchroniser, one delay flop for edge detection, registered pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_tick <= r_sync & ~r_prev;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/score_counter.sv
// Converts per-frame background scroll into a saturating score, one point per
// UNIT_DIST pixels, and keeps the best final score seen since reset.
module score_counter
  import doodle_pkg::*;
#(
  parameter int UNIT_DIST = 30,
  parameter int MAX_SCORE = 99,
  parameter int REM_W     = 12
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_clk,
  input  logic [9:0]         scroll_px,
  input  logic [2:0]         show,
  output logic [SCORE_W-1:0] score_num,
  output logic [SCORE_W-1:0] best_num,
  output logic               new_best,
  output logic               busy
);

  localparam logic [REM_W-1:0]   UNIT    = REM_W'(UNIT_DIST);
  localparam logic [REM_W:0]     REM_MAX = {1'b0, {REM_W{1'b1}}};
  localparam logic [SCORE_W-1:0] MAX     = SCORE_W'(MAX_SCORE);

  logic r_rst_meta;
  logic r_rst_sync;
  logic w_rst_n;

  score_state_t       r_state;
  score_state_t       w_state_next;
  logic [REM_W-1:0]   r_rem;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] r_best;
  logic               r_new_best;

  logic               w_tick;
  logic [REM_W:0]     w_rem_sum;
  logic [REM_W-1:0]   w_rem_sat;
  logic               w_dec;

  // Reset asserts immediately but releases only on a clock edge, two flops deep.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_rst_n = r_rst_sync;

  frame_tick_sync u_frame_tick_sync (
    .Clk      (Clk),
    .Reset_n  (w_rst_n),
    .async_in (frame_clk),
    .tick     (w_tick)
  );

  assign w_state_next = decode_show(show);

  // Add this frame's scroll only on a tick, clamping at the register ceiling
  // before any point is taken out so a huge burst never wraps.
  assign w_rem_sum = {1'b0, r_rem} + (w_tick ? (REM_W + 1)'(scroll_px) : '0);
  assign w_rem_sat = (w_rem_sum > REM_MAX) ? {REM_W{1'b1}} : w_rem_sum[REM_W-1:0];
  assign w_dec     = (r_rem >= UNIT) && (r_score < MAX);

  // Mode FSM with the remainder/score datapath and game-over best capture.
  always_ff @(posedge Clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= START;
      r_rem      <= '0;
      r_score    <= '0;
      r_best     <= '0;
      r_new_best <= 1'b0;
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        START: begin
          r_score    <= '0;
          r_rem      <= '0;
          r_new_best <= 1'b0;
        end
        PLAY: begin
          if (w_state_next == OVER) begin
            // Freeze the score on the way out; leftover pixels never score.
            if (r_score > r_best) begin
              r_best     <= r_score;
              r_new_best <= 1'b1;
            end
            r_rem <= '0;
          end else if (r_score >= MAX) begin
            r_rem <= '0;
          end else begin
            r_rem <= w_dec ? (w_rem_sat - UNIT) : w_rem_sat;
            if (w_dec) begin
              r_score <= r_score + SCORE_W'(1);
            end
          end
        end
        OVER: begin
          r_rem <= '0;
        end
        default: begin
          r_rem <= '0;
        end
      endcase
    end
  end

  assign score_num = r_score;
  assign best_num  = r_best;
  assign new_best  = r_new_best;
  assign busy      = (r_state == PLAY) && w_dec;

endmodule

// File: tb/tb_score_counter.sv
// Bench for score_counter: a per-cycle behavioural model of the scoring rules,
// checked against the DUT on every falling edge, plus hand-computed milestones.
module tb_score_counter;
  import doodle_pkg::*;

  localparam int UNIT = 30;
  localparam int MAXS = 99;
  localparam int RMAX = 4095;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_clk = 1'b0;
  logic [9:0]  scroll_px = '0;
  logic [2:0]  show = 3'd0;
  logic [10:0] score_num;
  logic [10:0] best_num;
  logic        new_best;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  score_counter #(.UNIT_DIST(UNIT), .MAX_SCORE(MAXS), .REM_W(12)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .scroll_px (scroll_px),
    .show      (show),
    .score_num (score_num),
    .best_num  (best_num),
    .new_best  (new_best),
    .busy      (busy)
  );

  always #10 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 start, 1 play, 2 over
  int m_mode = 0;
  int m_score = 0;
  int m_rem = 0;
  int m_best = 0;
  int m_nb = 0;
  int m_rel = 0;
  int m_fc[4] = '{0, 0, 0, 0};   // frame_clk seen at the last four clock edges

  always @(posedge Clk) begin
    int nxt;
    int use_tick;
    int r;
    if (!Reset_n || m_rel < 2) begin
      // reset plus two clocks for its synchronised release
      m_rel   = Reset_n ? m_rel + 1 : 0;
      m_mode  = 0; m_score = 0; m_rem = 0; m_best = 0; m_nb = 0;
      m_fc    = '{0, 0, 0, 0};
    end else begin
      // a frame edge first sampled at edge j acts at edge j+3
      use_tick = (m_fc[2] == 1 && m_fc[3] == 0) ? 1 : 0;
      nxt = (show == 3'd0) ? 0 : (show == 3'd3) ? 2 : 1;
      if (m_mode == 0) begin
        m_score = 0; m_rem = 0; m_nb = 0;
      end else if (m_mode == 2) begin
        m_rem = 0;
      end else if (nxt == 2) begin
        if (m_score > m_best) begin
          m_best = m_score; m_nb = 1;
        end
        m_rem = 0;
      end else if (m_score == MAXS) begin
        m_rem = 0;
      end else begin
        r = m_rem + (use_tick ? int'(scroll_px) : 0);
        if (r > RMAX) r = RMAX;
        if (m_rem >= UNIT) begin
          r = r - UNIT;
          m_score = m_score + 1;
        end
        m_rem = r;
      end
      m_mode = nxt;
      m_fc[3] = m_fc[2]; m_fc[2] = m_fc[1]; m_fc[1] = m_fc[0];
      m_fc[0] = int'(frame_clk);
    end
  end

  // per-cycle comparison against the model
  always @(negedge Clk) begin
    if (Reset_n) begin
      chk("score", int'(score_num), m_score);
      chk("best", int'(best_num), m_best);
      chk("new_best", int'(new_best), m_nb);
      chk("rem", int'(dut.r_rem), m_rem);
      chk("busy", int'(busy), (m_mode == 1 && m_rem >= UNIT && m_score < MAXS) ? 1 : 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic frame(input int px, output int busy_cycles);
    busy_cycles = 0;
    @(negedge Clk);
    scroll_px = 10'(px);
    frame_clk = 1'b1;
    @(negedge Clk);
    frame_clk = 1'b0;
    repeat (44) begin
      @(negedge Clk);
      if (busy) busy_cycles++;
    end
    $display("frame px=%0d -> score=%0d rem=%0d best=%0d new_best=%0d busy_cycles=%0d",
             px, score_num, dut.r_rem, best_num, new_best, busy_cycles);
  endtask

  task automatic set_show(input int code);
    @(negedge Clk);
    show = 3'(code);
    repeat (3) @(negedge Clk);
    $display("show=%0d -> score=%0d best=%0d new_best=%0d", code, score_num, best_num, new_best);
  endtask

  initial begin
    int bc;
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_score", int'(score_num), 0);
    chk("rst_best", int'(best_num), 0);
    chk("rst_nb", int'(new_best), 0);
    chk("rst_busy", int'(busy), 0);
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);

    // Game 1: slow accumulation, then reach 30 and end
    set_show(1);
    frame(20, bc); chk("t2_s0", int'(score_num), 0); chk("t2_r20", int'(dut.r_rem), 20);
    frame(20, bc); chk("t2_s1", int'(score_num), 1); chk("t2_r10", int'(dut.r_rem), 10);
    frame(20, bc); chk("t2_s2", int'(score_num), 2); chk("t2_r0", int'(dut.r_rem), 0);
    chk("t2_busy", int'(busy), 0);
    frame(840, bc); chk("g1_s30", int'(score_num), 30);
    set_show(3); chk("g1_best", int'(best_num), 30); chk("g1_nb", int'(new_best), 1);
    set_show(0); chk("g1_clr", int'(score_num), 0);

    // Game 2: burst, tick/decrement overlap, end at 42 beating 30
    set_show(1);
    frame(1023, bc);
    chk("t3_busy34", bc, 34); chk("t3_s34", int'(score_num), 34); chk("t3_r3", int'(dut.r_rem), 3);
    frame(27, bc); chk("t3_s35", int'(score_num), 35); chk("t3_r0", int'(dut.r_rem), 0);

    @(negedge Clk); scroll_px = 10'd70; frame_clk = 1'b1;
    @(negedge Clk); frame_clk = 1'b0;
    @(negedge Clk); frame_clk = 1'b1;
    @(negedge Clk);
    @(negedge Clk); scroll_px = 10'd25; chk("t6_r70", int'(dut.r_rem), 70);
    @(negedge Clk); frame_clk = 1'b0;   chk("t6_r40", int'(dut.r_rem), 40); chk("t6_s36", int'(score_num), 36);
    @(negedge Clk); chk("t6_r35", int'(dut.r_rem), 35); chk("t6_s37", int'(score_num), 37);
    $display("overlap -> score=%0d rem=%0d", score_num, dut.r_rem);
    repeat (6) @(negedge Clk);
    frame(115, bc); chk("g2_s42", int'(score_num), 42);
    set_show(3); chk("t5_best42", int'(best_num), 42); chk("t5_nb", int'(new_best), 1);
    frame(500, bc); chk("t5_hold", int'(score_num), 42);
    set_show(0);
    chk("t5_s0", int'(score_num), 0); chk("t5_nb0", int'(new_best), 0); chk("t5_keep", int'(best_num), 42);

    // Game 3: tie with the best score does not flag a new best
    set_show(1);
    frame(1020, bc); frame(240, bc); chk("g3_s42", int'(score_num), 42);
    set_show(3); chk("t6_tie_nb", int'(new_best), 0); chk("t6_tie_best", int'(best_num), 42);
    set_show(0);

    // Game 4: saturation
    set_show(1);
    frame(1020, bc); frame(1020, bc); frame(900, bc);
    chk("t4_s98", int'(score_num), 98); chk("t4_r0a", int'(dut.r_rem), 0);
    frame(90, bc);
    chk("t4_s99", int'(score_num), 99); chk("t4_r0", int'(dut.r_rem), 0); chk("t4_busy", int'(busy), 0);
    frame(500, bc); chk("t4_sat", int'(score_num), 99);
    set_show(0);

    // Reset mid-play
    set_show(1);
    frame(510, bc); chk("t1_s17", int'(score_num), 17);
    @(negedge Clk); #5 Reset_n = 1'b0; #1;
    chk("t1_score", int'(score_num), 0); chk("t1_best", int'(best_num), 0);
    chk("t1_nb", int'(new_best), 0); chk("t1_busy", int'(busy), 0);
    chk("t1_rem", int'(dut.r_rem), 0);
    $display("reset -> score=%0d best=%0d", score_num, best_num);
    @(negedge Clk); Reset_n = 1'b1; #1;
    chk("t1_state", int'(dut.r_state), int'(START));
    repeat (4) @(negedge Clk);
    frame(60, bc); chk("t1_restart", int'(score_num), 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
